// File: rtl/serial_sub_if.sv
// Start/busy/done handshake and operand/result bundle for serial_sub.
// Latency: n/a. Backpressure: none; the sequencer must wait for busy=0. The ovf signal exists only with SERIAL_SUB_OVF_EN.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop. Optional SERIAL_SUB_OVF_EN adds ovf.
// Latency: done pulses in the cycle after the WIDTH-th shift edge. Backpressure: start is ignored while busy.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  io_bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Only the upper WIDTH-1 bits are kept; the final bit goes straight to diff.
    logic [WIDTH-1:1] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic             r_bout;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_d;
    logic             w_brw_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_d       = r_a[0] ^ r_b[0] ^ r_brw;
    assign w_brw_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
    assign w_res_nxt = {w_d, r_res};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_brw   <= 1'b0;
            r_bout  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_accept) begin
                r_a   <= io_bus.a;
                r_b   <= io_bus.b;
                r_brw <= io_bus.bin;
                r_cnt <= '0;
            end else if (w_shift) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res_nxt[WIDTH-1:1];
                r_brw <= w_brw_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_diff <= w_res_nxt;
                r_bout <= w_brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
                // On the last shift r_a[0]/r_b[0] are the operand sign bits and w_d is the result sign.
                r_ovf  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
`endif
            end
        end
    end

    assign io_bus.busy = (r_state == S_SHIFT);
    assign io_bus.done = r_done;
    assign io_bus.diff = r_diff;
    assign io_bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign io_bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboarded random + directed bench for serial_sub; expected results pushed at issue, popped on done.
module tb_serial_sub;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errs   = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int   r;
        exp_t e;
        r      = int'(a) - int'(b) - int'(bin);
        e.diff = W'(r);
        e.bout = (r < 0);
        e.ovf  = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_done: got done=1, required no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_diff", 32'(bus.diff), 32'(mon_e.diff));
                check("sb_bout", 32'(bus.bout), 32'(mon_e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("sb_ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 4 * W) begin
            tick();
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 4 * W) begin
            tick();
            lat++;
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // Caller guarantees busy=0, so the next edge accepts.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        sb_q.push_back(model(a, b, bin));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat;
        wait_idle();
        run_op(a, b, bin);
        wait_done(lat);
        check("dir_diff", 32'(bus.diff), 32'(ed));
        check("dir_bout", 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check("dir_ovf", 32'(bus.ovf), 32'(eo));
`else
        if (eo !== 1'b0 && eo !== 1'b1) check("dir_ovf_arg", 32'(eo), 32'd0);
`endif
    endtask

    initial begin
        int lat, busy_cnt, t1, t2, seen;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency and busy window
        run_op(8'h05, 8'h03, 1'b0);
        busy_cnt = 0;
        lat      = 0;
        while (!bus.done && lat < 4 * W) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(W));
        check("busy_cycles", 32'(busy_cnt), 32'(W));
        check("lat_diff", 32'(bus.diff), 32'h02);
        check("lat_bout", 32'(bus.bout), 32'd0);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("diff_held", 32'(bus.diff), 32'h02);

        directed(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        directed(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        directed(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        directed(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // start held high, operands change mid-operation
        wait_idle();
        tick();
        bus.a = 8'h12; bus.b = 8'h34; bus.bin = 1'b0; bus.start = 1'b1;
        sb_q.push_back(model(8'h12, 8'h34, 1'b0));
        tick();
        repeat (3) tick();
        bus.a = 8'hC3; bus.b = 8'h3C; bus.bin = 1'b1;
        wait_done(lat);
        check("b2b_first_diff", 32'(bus.diff), 32'hDE);
        check("b2b_first_bout", 32'(bus.bout), 32'd1);
        t1 = cyc;
        sb_q.push_back(model(8'hC3, 8'h3C, 1'b1));
        tick();
        check("b2b_accept_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        bus.start = 1'b0;
        t2 = cyc;
        check("b2b_spacing", 32'(t2 - t1), 32'(W + 1));
        check("b2b_second_diff", 32'(bus.diff), 32'h86);

        // Reset mid-operation
        wait_idle();
        tick();
        bus.a = 8'hAA; bus.b = 8'h55; bus.bin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_bout", 32'(bus.bout), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 3) begin
            tick();
            if (bus.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        directed(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 200; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom));
        end
        wait_idle();
        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor; the inverse-direction companion to the combinational full adder `fa`.
- Loads two WIDTH-bit operands and a borrow-in, then computes a - b - bin LSB-first.
- Uses a single full-subtractor cell and a borrow flip-flop, one bit per clock.
- Used in the arithmetic datapath exercises where area matters more than latency; start/busy/done handshake to the controlling sequencer.

Parameters:
- WIDTH, 8: operand and result width in bits. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when diff/bout become valid
- diff  output  WIDTH  result a - b - bin mod 2^WIDTH
- bout  output  1  final borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. On any rising edge with rst_n=0, regardless of state: busy=0, done=0, diff=0, bout=0, borrow FF=0, bit counter=0, state=IDLE. Reset mid-operation aborts; no done is produced.
- States:
  - IDLE: busy=0. Edge with start=1 latches a, b and bin into shift registers/borrow FF, clears counter, goes to SHIFT; busy=1 from that edge.
  - SHIFT: each edge processes bit i=counter using the full subtractor:
    - d = a_i ^ b_i ^ brw
    - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw)
    - d shifts into the MSB of the result register (right shift), operand registers shift right, counter increments.
    - After the edge processing bit WIDTH-1: state=IDLE, busy=0, done=1, diff=completed result register, bout=final brw.
- Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH (WIDTH shift edges). Throughput is one operation per WIDTH+1 cycles minimum; start may be re-asserted in the cycle done is high and is accepted at that edge.
- done is high for exactly one cycle. diff/bout hold their value until the next done or reset. diff is not updated bit-by-bit externally; the internal result register is separate from the diff output register.
- start while busy=1 is ignored; the a/b/bin inputs are don't-care while busy.
- Counter width is $clog2(WIDTH)+1; no wrap occurs within an operation.
- Arithmetic: unsigned modulo 2^WIDTH. bout equals the borrow out of the MSB, identical to a WIDTH-bit ripple of full subtractors.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow, i.e. sign(a) != sign(b) and sign(diff) != sign(a).
  - Computed from captured operand MSBs and result MSB.
  - Registered and updated on the same edge as diff.
  - Reset value 0; held between operations.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05 b=0x03 bin=0, start one cycle -> busy high 8 cycles, done pulse at cycle 9, diff=0x02, bout=0 (ovf=0).
- a=0x03 b=0x05 bin=0 -> diff=0xFE, bout=1; a=0x00 b=0x00 bin=1 -> diff=0xFF, bout=1.
- With SERIAL_SUB_OVF_EN: a=0x80 b=0x01 bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F b=0xFF -> diff=0x80, bout=1, ovf=1.
- start held high continuously with a/b changed mid-operation -> operands from the first accepted edge used; next operation accepted on the done cycle, giving back-to-back done pulses WIDTH+1 cycles apart.
- rst_n=0 at shift cycle 4 of a=0xAA b=0x55 -> next edge busy=0, diff=0x00, bout=0, no done. A following start with the same operands -> diff=0x55, bout=0.
- Randomized 200 operations versus the reference model a - b - bin (9-bit compare of {bout,diff} against 9-bit two's complement result) -> zero mismatches.
